rsa_exp_ctrl: RTL and testbench

Front-end controller for the modular-exponentiation engine. It holds the RSA key (modulus, exponent) in a small write-port register file and accepts message blocks as a stream of 32-bit words. For each block it validates the operands, starts the engine, waits for completion, and returns the result as a two-word output stream. It sits between the SoC bus/DMA side and the engine, which the parent instantiates and wires to the eng_* ports.

---
 rtl/rsa_pkg.sv | 24 ++
 rtl/rsa_key_regs.sv | 42 ++++
 rtl/rsa_exp_ctrl.sv | 135 +++++++++++++
 tb/tb_rsa_exp_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA exponentiation front end.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package rsa_pkg;

    localparam int RSA_WIDTH = 32;

    // Key register file word addresses
    localparam logic [1:0] MOD_LO = 2'd0;
    localparam logic [1:0] MOD_HI = 2'd1;
    localparam logic [1:0] EXP_LO = 2'd2;
    localparam logic [1:0] EXP_HI = 2'd3;

    // Controller FSM encoding
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_RX_HI = 3'd1;
    localparam state_t ST_CHECK = 3'd2;
    localparam state_t ST_START = 3'd3;
    localparam state_t ST_WAIT  = 3'd4;
    localparam state_t ST_TX_LO = 3'd5;
    localparam state_t ST_TX_HI = 3'd6;

endpackage

// File: rtl/rsa_key_regs.sv
// Modulus/exponent register file written one WIDTH-bit word at a time.
// Latency: a write is visible on modulus/exponent the cycle after wr_en.
// Backpressure: none; writes outside idle are dropped and flagged on sticky wr_drop.
// Ports: clk, reset (sync, active-low), idle (write gate), wr_en/wr_addr/wr_data,
//        modulus/exponent (2*WIDTH key values), wr_drop (sticky dropped-write flag).
module rsa_key_regs
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               idle,
    input  logic               wr_en,
    input  logic [1:0]         wr_addr,
    input  logic [WIDTH-1:0]   wr_data,
    output logic [2*WIDTH-1:0] modulus,
    output logic [2*WIDTH-1:0] exponent,
    output logic               wr_drop
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            modulus  <= '0;
            exponent <= '0;
            wr_drop  <= 1'b0;
        end else if (wr_en) begin
            // The key must not change under a job in flight.
            if (idle) begin
                case (wr_addr)
                    MOD_LO:  modulus[WIDTH-1:0]        <= wr_data;
                    MOD_HI:  modulus[2*WIDTH-1:WIDTH]  <= wr_data;
                    EXP_LO:  exponent[WIDTH-1:0]       <= wr_data;
                    default: exponent[2*WIDTH-1:WIDTH] <= wr_data;
                endcase
            end else begin
                wr_drop <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/rsa_exp_ctrl.sv
// Front-end controller: takes 2-word message blocks, validates, runs the exp engine, returns 2 result words.
// Latency: hi word at N -> eng_start at N+2, first m_valid at N+4+L (L = exponent bit length); error blocks N+2.
// Backpressure: one block in flight; s_ready low from CHECK until IDLE, result words held until m_ready.
// Ports: clk, reset (sync, active-low), key write port (wr_*), message stream (s_*),
//        result stream (m_*, m_last on hi word, m_err), busy, wr_drop, engine port (eng_*).
module rsa_exp_ctrl
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [1:0]         wr_addr,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [WIDTH-1:0]   s_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [WIDTH-1:0]   m_data,
    output logic               m_last,
    output logic               m_err,
    output logic               busy,
    output logic               wr_drop,
    output logic [2*WIDTH-1:0] eng_base,
    output logic [2*WIDTH-1:0] eng_modulo,
    output logic [2*WIDTH-1:0] eng_exponent,
    output logic               eng_start,
    input  logic               eng_finish,
    input  logic [2*WIDTH-1:0] eng_result
);

    state_t               state;
    logic [2*WIDTH-1:0]   msg;
    logic [2*WIDTH-1:0]   result;
    logic                 err;
    logic [2*WIDTH-1:0]   modulus;
    logic [2*WIDTH-1:0]   exponent;
    logic                 s_acc;
    logic                 operands_ok;

    rsa_key_regs #(.WIDTH(WIDTH)) u_key_regs (
        .clk      (clk),
        .reset    (reset),
        .idle     (state == ST_IDLE),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .modulus  (modulus),
        .exponent (exponent),
        .wr_drop  (wr_drop)
    );

    // Gated by reset so no word is taken (or advertised) while reset is held.
    assign s_ready = reset && ((state == ST_IDLE) || (state == ST_RX_HI));
    assign s_acc   = s_valid && s_ready;

    assign busy      = (state != ST_IDLE);
    assign eng_start = (state == ST_START);
    assign m_valid   = (state == ST_TX_LO) || (state == ST_TX_HI);
    assign m_last    = (state == ST_TX_HI);
    assign m_err     = m_valid && err;
    assign m_data    = (state == ST_TX_HI) ? result[2*WIDTH-1:WIDTH] : result[WIDTH-1:0];

    // The engine keeps only 2*WIDTH bits of every product, so operands must
    // stay below 2^WIDTH for the result to be exact; modulus 0/1 is meaningless.
    assign operands_ok = (modulus[2*WIDTH-1:WIDTH] == '0)
                      && (modulus[WIDTH-1:0] >= WIDTH'(2))
                      && (msg[2*WIDTH-1:WIDTH] == '0)
                      && (msg[WIDTH-1:0] < modulus[WIDTH-1:0]);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= ST_IDLE;
            msg          <= '0;
            result       <= '0;
            err          <= 1'b0;
            eng_base     <= '0;
            eng_modulo   <= '0;
            eng_exponent <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (s_acc) begin
                        msg[WIDTH-1:0] <= s_data;
                        state          <= ST_RX_HI;
                    end
                end
                ST_RX_HI: begin
                    if (s_acc) begin
                        msg[2*WIDTH-1:WIDTH] <= s_data;
                        state                <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (operands_ok) begin
                        // Loaded here so the buses are already valid during START.
                        eng_base     <= msg;
                        eng_modulo   <= modulus;
                        eng_exponent <= exponent;
                        err          <= 1'b0;
                        state        <= ST_START;
                    end else begin
                        result <= '0;
                        err    <= 1'b1;
                        state  <= ST_TX_LO;
                    end
                end
                ST_START: begin
                    // eng_finish is ignored here: it may still show the previous job.
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (eng_finish) begin
                        result <= eng_result;
                        state  <= ST_TX_LO;
                    end
                end
                ST_TX_LO: begin
                    if (m_ready) begin
                        state <= ST_TX_HI;
                    end
                end
                ST_TX_HI: begin
                    if (m_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_exp_ctrl.sv
// Directed bench for rsa_exp_ctrl with a behavioural exponentiation engine.
// Latency: n/a.
// Backpressure: n/a.
module tb_rsa_exp_ctrl;
    import rsa_pkg::*;

    localparam int WIDTH = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = '0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] m_data;
    logic        m_last;
    logic        m_err;
    logic        busy;
    logic        wr_drop;
    logic [63:0] eng_base;
    logic [63:0] eng_modulo;
    logic [63:0] eng_exponent;
    logic        eng_start;
    logic        eng_finish = 1'b0;
    logic [63:0] eng_result = '0;

    rsa_exp_ctrl #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .m_err(m_err), .busy(busy), .wr_drop(wr_drop),
        .eng_base(eng_base), .eng_modulo(eng_modulo), .eng_exponent(eng_exponent),
        .eng_start(eng_start), .eng_finish(eng_finish), .eng_result(eng_result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // ---------------- behavioural engine ----------------
    function automatic logic [63:0] model_exp(input logic [63:0] b, input logic [63:0] e,
                                              input logic [63:0] m);
        logic [127:0] r;
        logic [127:0] x;
        if (m == 64'd0) return 64'd0;
        r = 128'd1;
        x = {64'd0, b} % {64'd0, m};
        for (int i = 0; i < 64; i++) begin
            if (e[i]) r = (r * x) % {64'd0, m};
            x = (x * x) % {64'd0, m};
        end
        return r[63:0];
    endfunction

    function automatic int msb_len(input logic [63:0] e);
        for (int i = 63; i >= 0; i--) if (e[i]) return i + 1;
        return 0;
    endfunction

    logic        start_seen = 1'b0;
    logic [63:0] base_s = '0, mod_s = '0, exp_s = '0;
    int          eng_cnt = 0;
    int          start_cnt = 0;

    always @(negedge clk) begin
        start_seen <= eng_start;
        base_s     <= eng_base;
        mod_s      <= eng_modulo;
        exp_s      <= eng_exponent;
    end

    // Finish stays high after completion until the next load, like a real done level.
    always @(posedge clk) begin
        if (start_seen) begin
            start_cnt  <= start_cnt + 1;
            eng_result <= model_exp(base_s, exp_s, mod_s);
            eng_cnt    <= msb_len(exp_s);
            eng_finish <= (msb_len(exp_s) == 0);
        end else if (eng_cnt > 0) begin
            eng_cnt    <= eng_cnt - 1;
            eng_finish <= (eng_cnt == 1);
        end
    end

    // ---------------- stimulus helpers (start and end on a negedge) ----------------
    task automatic key_write(input logic [1:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic load_key(input logic [63:0] m, input logic [63:0] e);
        key_write(MOD_LO, m[31:0]);
        key_write(MOD_HI, m[63:32]);
        key_write(EXP_LO, e[31:0]);
        key_write(EXP_HI, e[63:32]);
    endtask

    task automatic send_word(input logic [31:0] d, output int acc_cyc);
        int n = 0;
        s_valid = 1'b1; s_data = d;
        while (!s_ready && n < 200) begin @(negedge clk); n++; end
        if (!s_ready) check("send_timeout", 64'd0, 64'd1);
        acc_cyc = cyc;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic recv_result(output logic [31:0] lo, output logic [31:0] hi,
                               output logic e0, output logic e1,
                               output logic l0, output logic l1, output int first_cyc);
        int n = 0;
        m_ready = 1'b1;
        while (!m_valid && n < 400) begin @(negedge clk); n++; end
        if (!m_valid) check("recv_timeout", 64'd0, 64'd1);
        first_cyc = cyc;
        lo = m_data; e0 = m_err; l0 = m_last;
        @(negedge clk);
        if (!m_valid) check("recv_hi_valid", 64'd0, 64'd1);
        hi = m_data; e1 = m_err; l1 = m_last;
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    task automatic wait_start(input string name);
        int n = 0;
        while (!eng_start && n < 50) begin @(negedge clk); n++; end
        if (!eng_start) check(name, 64'd0, 64'd1);
        @(negedge clk);
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        string       name;
        logic [63:0] modv;
        logic [63:0] expv;
        logic [31:0] mlo;
        logic [31:0] mhi;
        logic [31:0] rlo;
        logic [31:0] rhi;
        logic        err;
        int          lat;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs[NV];

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] lo, hi, lo1, hi1;
        logic        e0, e1, l0, l1;
        int          c0, c1, fc, s0, hs_cyc, acc_cyc, n, seen;

        vecs[0] = '{"enc",        64'd3233, 64'd17,   32'd65,   32'd0, 32'd2790, 32'd0, 1'b0, 9};
        vecs[1] = '{"dec",        64'd3233, 64'd2753, 32'd2790, 32'd0, 32'd65,   32'd0, 1'b0, 16};
        vecs[2] = '{"exp_zero",   64'd3233, 64'd0,    32'd123,  32'd0, 32'd1,    32'd0, 1'b0, 4};
        vecs[3] = '{"mod_one",    64'd1,    64'd17,   32'd0,    32'd0, 32'd0,    32'd0, 1'b1, 2};
        vecs[4] = '{"mod_hi",     64'h0000_0001_0000_0CA1, 64'd17, 32'd65, 32'd0, 32'd0, 32'd0, 1'b1, 2};
        vecs[5] = '{"msg_big",    64'd3233, 64'd17,   32'd4000, 32'd0, 32'd0,    32'd0, 1'b1, 2};
        vecs[6] = '{"msg_hi",     64'd3233, 64'd17,   32'd65,   32'd1, 32'd0,    32'd0, 1'b1, 2};
        vecs[7] = '{"msg_eq_mod", 64'd3233, 64'd17,   32'd3233, 32'd0, 32'd0,    32'd0, 1'b1, 2};
        vecs[8] = '{"msg_max",    64'd3233, 64'd17,   32'd3232, 32'd0, 32'd3232, 32'd0, 1'b0, 9};
        vecs[9] = '{"mod_two",    64'd2,    64'd5,    32'd1,    32'd0, 32'd1,    32'd0, 1'b0, 7};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_s_ready", s_ready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_last", m_last, 0);
        check("rst_m_err", m_err, 0);
        check("rst_busy", busy, 0);
        check("rst_wr_drop", wr_drop, 0);
        check("rst_eng_start", eng_start, 0);
        check("rst_eng_base", eng_base, 0);
        check("rst_eng_modulo", eng_modulo, 0);
        check("rst_eng_exponent", eng_exponent, 0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_s_ready", s_ready, 1);

        // Table-driven blocks
        for (int i = 0; i < NV; i++) begin
            load_key(vecs[i].modv, vecs[i].expv);
            s0 = start_cnt;
            send_word(vecs[i].mlo, c0);
            send_word(vecs[i].mhi, c1);
            recv_result(lo, hi, e0, e1, l0, l1, fc);
            check({vecs[i].name, "_lo"}, lo, vecs[i].rlo);
            check({vecs[i].name, "_hi"}, hi, vecs[i].rhi);
            check({vecs[i].name, "_err0"}, e0, vecs[i].err);
            check({vecs[i].name, "_err1"}, e1, vecs[i].err);
            check({vecs[i].name, "_last0"}, l0, 0);
            check({vecs[i].name, "_last1"}, l1, 1);
            check({vecs[i].name, "_lat"}, fc - c1, vecs[i].lat);
            check({vecs[i].name, "_starts"}, start_cnt - s0, vecs[i].err ? 0 : 1);
        end

        // Backpressure in TX_LO with a pending input word
        load_key(64'd3233, 64'd17);
        send_word(32'd65, c0);
        send_word(32'd0, c1);
        s_valid = 1'b1; s_data = 32'd77;
        n = 0;
        while (!m_valid && n < 50) begin @(negedge clk); n++; end
        check("bp_eng_base", eng_base, 65);
        check("bp_eng_modulo", eng_modulo, 3233);
        check("bp_eng_exponent", eng_exponent, 17);
        for (int k = 0; k < 5; k++) begin
            check("bp_m_valid", m_valid, 1);
            check("bp_m_data", m_data, 2790);
            check("bp_m_last", m_last, 0);
            check("bp_s_ready", s_ready, 0);
            @(negedge clk);
        end
        s_valid = 1'b0;
        recv_result(lo, hi, e0, e1, l0, l1, fc);
        check("bp_lo", lo, 2790);
        check("bp_hi", hi, 0);
        check("bp_idle_after", busy, 0);

        // Key write while the engine runs is dropped
        send_word(32'd65, c0);
        send_word(32'd0, c1);
        wait_start("kw_start_timeout");
        check("kw_busy", busy, 1);
        key_write(MOD_LO, 32'd7);
        key_write(EXP_LO, 32'd3);
        check("kw_wr_drop", wr_drop, 1);
        recv_result(lo, hi, e0, e1, l0, l1, fc);
        check("kw_lo", lo, 2790);
        send_word(32'd65, c0);
        send_word(32'd0, c1);
        recv_result(lo, hi, e0, e1, l0, l1, fc);
        check("kw_key_kept_lo", lo, 2790);
        check("kw_wr_drop_sticky", wr_drop, 1);

        // Reset in the middle of WAIT
        send_word(32'd65, c0);
        send_word(32'd0, c1);
        wait_start("rw_start_timeout");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rw_s_ready", s_ready, 0);
        check("rw_m_valid", m_valid, 0);
        check("rw_m_last", m_last, 0);
        check("rw_m_err", m_err, 0);
        check("rw_m_data", m_data, 0);
        check("rw_busy", busy, 0);
        check("rw_wr_drop", wr_drop, 0);
        check("rw_eng_start", eng_start, 0);
        check("rw_eng_base", eng_base, 0);
        check("rw_eng_modulo", eng_modulo, 0);
        check("rw_eng_exponent", eng_exponent, 0);
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            if (m_valid) seen++;
            @(negedge clk);
        end
        check("rw_no_output", seen, 0);
        load_key(64'd3233, 64'd2753);
        send_word(32'd2790, c0);
        send_word(32'd0, c1);
        recv_result(lo, hi, e0, e1, l0, l1, fc);
        check("rw_after_lo", lo, 65);
        check("rw_after_lat", fc - c1, 16);

        // Back-to-back blocks with s_valid held high
        load_key(64'd3233, 64'd17);
        send_word(32'd65, c0);
        s_valid = 1'b1; s_data = 32'd0;
        n = 0;
        while (!s_ready && n < 10) begin @(negedge clk); n++; end
        c1 = cyc;
        @(negedge clk);
        s_data = 32'd3232;
        m_ready = 1'b1;
        lo1 = '1; hi1 = '1; hs_cyc = -100; acc_cyc = -1; fc = -1;
        n = 0;
        while (n < 100) begin
            if (m_valid && !m_last) begin lo1 = m_data; fc = cyc; end
            if (m_valid && m_last) begin hi1 = m_data; hs_cyc = cyc; end
            if (s_ready) begin acc_cyc = cyc; break; end
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        m_ready = 1'b0;
        check("b2b_first_lo", lo1, 2790);
        check("b2b_first_hi", hi1, 0);
        check("b2b_first_lat", fc - c1, 9);
        check("b2b_accept_after_hs", acc_cyc - hs_cyc, 1);
        s0 = start_cnt;
        send_word(32'd0, c1);
        recv_result(lo, hi, e0, e1, l0, l1, fc);
        check("b2b_second_lo", lo, 3232);
        check("b2b_second_lat", fc - c1, 9);
        check("b2b_second_starts", start_cnt - s0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
